// File: rtl/rs_lab_pkg.sv
// Shared definitions for the RS flip-flop lab: command encoding and
// input-conditioning constants.
package rs_lab_pkg;

    typedef enum logic [1:0] {
        RS_CMD_NONE = 2'd0,
        RS_CMD_SET  = 2'd1,
        RS_CMD_RST  = 2'd2
    } rs_cmd_e;

    localparam int SYNC_STAGES             = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/rs_cmd_conditioner_if.sv
// Button inputs and conditioned command outputs of the RS command conditioner.
interface rs_cmd_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             set_btn;
    logic             reset_btn;
    logic             S;
    logic             R;
    logic             exp_q;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        input  set_btn, reset_btn,
        output S, R, exp_q, cmd_count
    );

    modport slave (
        output set_btn, reset_btn,
        input  S, R, exp_q, cmd_count
    );
endinterface

// File: rtl/rs_debounce.sv
// One button channel: synchroniser, stability counter, debounced level and a
// registered one-cycle pulse on each accepted 0->1 transition.
module rs_debounce
    import rs_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic clear,
    input  logic btn,
    output logic rise
);
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("rs_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic                   db;
    logic [CW-1:0]          cnt;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (clear) begin
            sync <= '0;
            db   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            rise <= 1'b0;
            if (synced == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // The increment that would reach DEBOUNCE_CYCLES accepts the level.
                db   <= synced;
                cnt  <= '0;
                rise <= synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_cmd_conditioner.sv
// Turns two raw push buttons into mutually exclusive one-cycle S/R pulses, with
// an expected-Q mirror and an issued-command counter.
module rs_cmd_conditioner
    import rs_lab_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int PRIORITY_RESET  = 1,
    parameter int CNT_W           = 8
) (
    input  logic                    clk,
    input  logic                    clear,
    rs_cmd_conditioner_if.master    cmd
);
    logic             rise_s;
    logic             rise_r;
    logic             pend_s;
    logic             pend_r;
    logic             s_q;
    logic             r_q;
    logic             q_q;
    logic [CNT_W-1:0] count;
    rs_cmd_e          issue;

    rs_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .clear (clear),
        .btn   (cmd.set_btn),
        .rise  (rise_s)
    );

    rs_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk   (clk),
        .clear (clear),
        .btn   (cmd.reset_btn),
        .rise  (rise_r)
    );

    always_comb begin
        issue = RS_CMD_NONE;
        if (pend_s && pend_r)
            issue = (PRIORITY_RESET != 0) ? RS_CMD_RST : RS_CMD_SET;
        else if (pend_s)
            issue = RS_CMD_SET;
        else if (pend_r)
            issue = RS_CMD_RST;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            q_q    <= 1'b0;
            count  <= '0;
        end else begin
            // A rise on an already-pending channel merges into the same flag.
            pend_s <= (pend_s && issue != RS_CMD_SET) || rise_s;
            pend_r <= (pend_r && issue != RS_CMD_RST) || rise_r;
            s_q    <= (issue == RS_CMD_SET);
            r_q    <= (issue == RS_CMD_RST);
            if (issue == RS_CMD_SET)
                q_q <= 1'b1;
            else if (issue == RS_CMD_RST)
                q_q <= 1'b0;
            if (issue != RS_CMD_NONE)
                count <= count + 1'b1;
        end
    end

    assign cmd.S         = s_q;
    assign cmd.R         = r_q;
    assign cmd.exp_q     = q_q;
    assign cmd.cmd_count = count;
endmodule

// File: tb/tb_rs_cmd_conditioner.sv
// Directed bench for rs_cmd_conditioner with DEBOUNCE_CYCLES=4, R priority, 8-bit count.
module tb_rs_cmd_conditioner;
    logic clk;
    logic clear;

    rs_cmd_conditioner_if #(.CNT_W(8)) bus ();

    rs_cmd_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .PRIORITY_RESET  (1),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .cmd   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n      = 0;
    int s_pulses    = 0;
    int r_pulses    = 0;
    int overlaps    = 0;
    int last_s_edge = -1;
    int last_r_edge = -1;
    logic q_at_r    = 1'b1;

    int n_checks = 0;
    int n_fails  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Pulse bookkeeping, sampled mid-cycle; edge numbers refer to the registering edge.
    always @(negedge clk) begin
        if (bus.S === 1'b1) begin
            s_pulses    = s_pulses + 1;
            last_s_edge = edge_n;
        end
        if (bus.R === 1'b1) begin
            r_pulses    = r_pulses + 1;
            last_r_edge = edge_n;
            q_at_r      = bus.exp_q;
        end
        if (bus.S === 1'b1 && bus.R === 1'b1)
            overlaps = overlaps + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges and park 2 time units after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic is_set);
        if (is_set) bus.set_btn = 1'b1;
        else        bus.reset_btn = 1'b1;
        step(7);
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        step(7);
    endtask

    int e, s0, r0;

    initial begin
        // 1: clear with both buttons high
        clear         = 1'b1;
        bus.set_btn   = 1'b1;
        bus.reset_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("clr_S", bus.S, 0);
            check_eq("clr_R", bus.R, 0);
            check_eq("clr_q", bus.exp_q, 0);
            check_eq("clr_cnt", bus.cmd_count, 0);
        end
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        step(4);
        clear = 1'b0;
        step(4);
        check_eq("idle_cnt", bus.cmd_count, 0);

        // 2: single set press, S 7 edges after first sample
        s0 = s_pulses; r0 = r_pulses; e = edge_n;
        bus.set_btn = 1'b1;
        step(12);
        bus.set_btn = 1'b0;
        step(10);
        check_eq("set_npulse", s_pulses - s0, 1);
        check_eq("set_edge", last_s_edge, e + 8);
        check_eq("set_noR", r_pulses - r0, 0);
        check_eq("set_q", bus.exp_q, 1);
        check_eq("set_cnt", bus.cmd_count, 1);

        // 3: short bounces never accepted
        s0 = s_pulses; r0 = r_pulses;
        for (int i = 0; i < 5; i++) begin
            bus.set_btn = 1'b1;
            step(3);
            bus.set_btn = 1'b0;
            step(3);
        end
        step(6);
        check_eq("bnc_S", s_pulses - s0, 0);
        check_eq("bnc_R", r_pulses - r0, 0);
        check_eq("bnc_cnt", bus.cmd_count, 1);

        // 4: simultaneous rise, R wins then S follows
        s0 = s_pulses; r0 = r_pulses; e = edge_n;
        bus.set_btn   = 1'b1;
        bus.reset_btn = 1'b1;
        step(12);
        bus.set_btn   = 1'b0;
        bus.reset_btn = 1'b0;
        step(10);
        check_eq("cf_nR", r_pulses - r0, 1);
        check_eq("cf_nS", s_pulses - s0, 1);
        check_eq("cf_Redge", last_r_edge, e + 8);
        check_eq("cf_Sedge", last_s_edge, e + 9);
        check_eq("cf_q_at_R", q_at_r, 0);
        check_eq("cf_q", bus.exp_q, 1);
        check_eq("cf_cnt", bus.cmd_count, 3);
        check_eq("cf_overlap", overlaps, 0);

        // 5: clear mid-debounce drops progress; held button restarts after clear
        r0 = r_pulses; e = edge_n;
        bus.reset_btn = 1'b1;
        step(4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("mc_cnt0", bus.cmd_count, 0);
        check_eq("mc_q0", bus.exp_q, 0);
        step(12);
        bus.reset_btn = 1'b0;
        step(10);
        check_eq("mc_nR", r_pulses - r0, 1);
        check_eq("mc_Redge", last_r_edge, e + 13);
        check_eq("mc_cnt", bus.cmd_count, 1);

        // 6: 256 alternating presses from a cleared counter
        clear = 1'b1;
        step(2);
        clear = 1'b0;
        step(2);
        s0 = s_pulses; r0 = r_pulses;
        for (int i = 0; i < 255; i++)
            press((i % 2) == 0);
        check_eq("wr_cnt255", bus.cmd_count, 255);
        check_eq("wr_q255", bus.exp_q, 1);
        press(1'b0);
        check_eq("wr_cnt0", bus.cmd_count, 0);
        check_eq("wr_q", bus.exp_q, 0);
        check_eq("wr_nS", s_pulses - s0, 128);
        check_eq("wr_nR", r_pulses - r0, 128);
        check_eq("wr_overlap", overlaps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
